// File: rtl/arm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipe_pkg
// Shared definitions for the ARM pipeline hazard/forwarding logic.
//   REG_AW      : architectural register-address width (16 registers)
//   FWD_RF      : forward-select code meaning "operand comes from the regfile"
//   FWD_MEM     : forward-select code for the stage right after EXE; stage j
//                 after EXE is encoded as FWD_MEM + (j - 1)
//   trk_entry_t : one in-flight destination tracked between ID and WB
// Optional feature macro used by the consumers of this package:
//   ARM_FORWARDING_EN
// -----------------------------------------------------------------------------
package arm_pipe_pkg;

  localparam int REG_AW  = 4;
  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              is_load;
    logic [REG_AW-1:0] dest;
  } trk_entry_t;

endpackage

// File: rtl/arm_hazard_tracker_entry.sv
// -----------------------------------------------------------------------------
// arm_hazard_tracker_entry
// One slot of the in-flight destination shift-pipeline. Captures i_entry when
// i_take is high, otherwise loads a bubble (all fields cleared).
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset, clears the slot
//   i_take         in   capture i_entry this cycle (else bubble)
//   i_entry        in   entry presented by the previous stage (or ID)
//   o_entry        out  registered slot contents
//   o_load_pending out  slot holds a load whose data is not yet forwardable
// Parameters:
//   INDEX       position of this slot (0 = EXE)
//   LOAD_STAGE  first slot index from which load data can be forwarded
// -----------------------------------------------------------------------------
module arm_hazard_tracker_entry
  import arm_pipe_pkg::*;
#(
  parameter int INDEX      = 0,
  parameter int LOAD_STAGE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_take,
  input  trk_entry_t i_entry,
  output trk_entry_t o_entry,
  output logic       o_load_pending
);

  // Slots ahead of the load-data stage still see a load as unresolved.
  localparam logic EARLY_SLOT = (INDEX < LOAD_STAGE) ? 1'b1 : 1'b0;

  trk_entry_t r_entry;

  // Slot register: capture the incoming entry or fall back to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '{valid: 1'b0, wb_en: 1'b0, is_load: 1'b0, dest: {REG_AW{1'b0}}};
    end else if (i_take) begin
      r_entry <= i_entry;
    end else begin
      r_entry <= '{valid: 1'b0, wb_en: 1'b0, is_load: 1'b0, dest: {REG_AW{1'b0}}};
    end
  end

  assign o_entry        = r_entry;
  assign o_load_pending = EARLY_SLOT & r_entry.valid & r_entry.is_load;

endmodule

// File: rtl/arm_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// arm_hazard_scoreboard
// Hazard/forwarding unit: tracks in-flight destinations in a PIPE_DEPTH-slot
// shift-pipeline (slot 0 = EXE), stalls IF/ID on unresolved dependencies,
// produces registered EXE forward selects and counts stall cycles.
// Ports:
//   clk, rst             clock (rising) / asynchronous active-low reset
//   id_valid             ID holds a real instruction
//   id_wb_en             ID instruction writes a register
//   id_mem_read          ID instruction is a load
//   id_dest              ID destination register
//   src1, src2           ID source registers (Rn, Rm/Rd-for-store)
//   one_src, two_src     src1 / src2 are actually read
//   flush                branch taken: squash the ID instruction
//   stall                freeze PC and IF/ID, bubble into ID/EXE
//   sel_src1, sel_src2   EXE forward select: 0 = regfile, j = stage j after EXE
//   stall_cnt            saturating stall-cycle counter
// Configuration macro:
//   ARM_FORWARDING_EN    defined  : forward from any slot, stall only on load-use
//                        undefined: stall on any match, selects tied to 0
// -----------------------------------------------------------------------------
module arm_hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter  int PIPE_DEPTH = 2,
  parameter  int LOAD_STAGE = 1,
  parameter  int CNT_W      = 16,
  localparam int SW         = $clog2(PIPE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              one_src,
  input  logic              two_src,
  input  logic              flush,
  output logic              stall,
  output logic [SW-1:0]     sel_src1,
  output logic [SW-1:0]     sel_src2,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  trk_entry_t            w_entry   [PIPE_DEPTH];
  trk_entry_t            w_slot_in [PIPE_DEPTH];
  logic                  w_slot_take [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] w_load_pending;
  trk_entry_t            w_id_entry;
  logic [PIPE_DEPTH-1:0] w_m1;
  logic [PIPE_DEPTH-1:0] w_m2;
  logic                  w_hazard;
  logic                  w_issue;
  logic [CNT_W-1:0]      r_stall_cnt;

  // Stall is suppressed by flush (flush wins) and when ID is empty.
  assign stall   = w_hazard & id_valid & ~flush;
  assign w_issue = id_valid & ~stall & ~flush;

  // Pack the ID instruction into a tracker entry.
  always_comb begin
    w_id_entry = '{valid: 1'b1, wb_en: id_wb_en, is_load: id_mem_read, dest: id_dest};
  end

  // Slot chain: slot 0 fed by ID, every later slot by its predecessor.
  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign w_slot_in[g]   = w_id_entry;
      assign w_slot_take[g] = w_issue;
    end else begin : g_body
      assign w_slot_in[g]   = w_entry[g-1];
      assign w_slot_take[g] = 1'b1;
    end

    arm_hazard_tracker_entry #(
      .INDEX      (g),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_entry (
      .clk            (clk),
      .rst_n          (rst),
      .i_take         (w_slot_take[g]),
      .i_entry        (w_slot_in[g]),
      .o_entry        (w_entry[g]),
      .o_load_pending (w_load_pending[g])
    );
  end

  // Per-slot source matches; R15 gets no special treatment.
  always_comb begin
    w_m1 = {PIPE_DEPTH{1'b0}};
    w_m2 = {PIPE_DEPTH{1'b0}};
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_m1[k] = one_src & w_entry[k].valid & w_entry[k].wb_en & (w_entry[k].dest == src1);
      w_m2[k] = two_src & w_entry[k].valid & w_entry[k].wb_en & (w_entry[k].dest == src2);
    end
  end

`ifdef ARM_FORWARDING_EN

  localparam logic [PIPE_DEPTH-1:0] LSB_ONE = {{(PIPE_DEPTH-1){1'b0}}, 1'b1};

  logic [PIPE_DEPTH-1:0] w_first1;
  logic [PIPE_DEPTH-1:0] w_first2;
  logic [SW-1:0]         w_idx1;
  logic [SW-1:0]         w_idx2;
  logic [SW-1:0]         r_sel1;
  logic [SW-1:0]         r_sel2;
  logic                  w_unused_tail;

  // Youngest match = lowest set bit; only it decides load-use and the select.
  always_comb begin
    w_first1 = w_m1 & (~w_m1 + LSB_ONE);
    w_first2 = w_m2 & (~w_m2 + LSB_ONE);
    w_idx1   = {SW{1'b0}};
    w_idx2   = {SW{1'b0}};
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_idx1 = w_first1[k] ? SW'(k) : w_idx1;
      w_idx2 = w_first2[k] ? SW'(k) : w_idx2;
    end
    w_hazard = (|(w_first1 & w_load_pending)) | (|(w_first2 & w_load_pending));
  end

  // EXE forward selects: the producer moves one slot as the consumer enters EXE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel1 <= SW'(FWD_RF);
      r_sel2 <= SW'(FWD_RF);
    end else begin
      r_sel1 <= (w_issue & (|w_m1)) ? (w_idx1 + SW'(FWD_MEM)) : SW'(FWD_RF);
      r_sel2 <= (w_issue & (|w_m2)) ? (w_idx2 + SW'(FWD_MEM)) : SW'(FWD_RF);
    end
  end

  assign sel_src1 = r_sel1;
  assign sel_src2 = r_sel2;

  // The last slot's load flag has no further consumer.
  assign w_unused_tail = w_entry[PIPE_DEPTH-1].is_load;

`else

  logic w_unused_tail;

  // Without forwarding any in-flight producer blocks the consumer.
  always_comb begin
    w_hazard = (|w_m1) | (|w_m2);
  end

  assign sel_src1 = {SW{1'b0}};
  assign sel_src2 = {SW{1'b0}};

  // Load tracking only matters when forwarding is built in.
  assign w_unused_tail = ^{w_load_pending, w_entry[PIPE_DEPTH-1].is_load};

`endif

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_arm_hazard_scoreboard
// Directed self-checking bench for arm_hazard_scoreboard (PIPE_DEPTH=2,
// LOAD_STAGE=1, CNT_W=4). Expected values are hand-derived for both settings
// of ARM_FORWARDING_EN.
// -----------------------------------------------------------------------------
module tb_arm_hazard_scoreboard;

  localparam int PD = 2;
  localparam int LS = 1;
  localparam int CW = 4;
  localparam int SW = $clog2(PD + 1);

`ifdef ARM_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_wb_en, id_mem_read;
  logic [3:0]    id_dest, src1, src2;
  logic          one_src, two_src, flush;
  logic          stall;
  logic [SW-1:0] sel_src1, sel_src2;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  arm_hazard_scoreboard #(
    .PIPE_DEPTH (PD),
    .LOAD_STAGE (LS),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .id_dest     (id_dest),
    .src1        (src1),
    .src2        (src2),
    .one_src     (one_src),
    .two_src     (two_src),
    .flush       (flush),
    .stall       (stall),
    .sel_src1    (sel_src1),
    .sel_src2    (sel_src2),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic o1, input logic o2, input logic fl);
    id_valid = v; id_wb_en = wb; id_mem_read = ld; id_dest = d;
    src1 = s1; src2 = s2; one_src = o1; two_src = o2; flush = fl;
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop(); step(); step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    nop();
    step(); step();
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: actual=%0b required=0", stall); end
    n_checks++; if (sel_src1 !== 2'd0) begin n_fail++; $display("FAIL reset_sel1: actual=%0d required=0", sel_src1); end
    n_checks++; if (sel_src2 !== 2'd0) begin n_fail++; $display("FAIL reset_sel2: actual=%0d required=0", sel_src2); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: actual=%0d required=0", stall_cnt); end
    step();
    rst = 1'b1;
  endtask

  // ADD r1 ; SUB r2,r1,r5 back to back
  task automatic test_fwd_exe();
    int n;
    n = FWD ? 0 : 2;
    drain();
    issue(1'b1, 1'b1, 1'b0, 4'd1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t1_prod_stall: actual=%0b required=0", stall); end
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== (i < n)) begin n_fail++; $display("FAIL t1_stall[%0d]: actual=%0b required=%0b", i, stall, (i < n)); end
      step();
    end
    n_checks++; if (sel_src1 !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL t1_sel1: actual=%0d required=%0d", sel_src1, (FWD ? 1 : 0)); end
    n_checks++; if (sel_src2 !== 2'd0) begin n_fail++; $display("FAIL t1_sel2: actual=%0d required=0", sel_src2); end
    nop();
    exp_cnt += n;
    n_checks++; if (stall_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL t1_cnt: actual=%0d required=%0d", stall_cnt, exp_cnt); end
  endtask

  // ADD r1 ; NOP ; SUB r2,r1,r6
  task automatic test_fwd_wb();
    int n;
    n = FWD ? 0 : 1;
    drain();
    issue(1'b1, 1'b1, 1'b0, 4'd1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    nop();
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd6, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== (i < n)) begin n_fail++; $display("FAIL t2_stall[%0d]: actual=%0b required=%0b", i, stall, (i < n)); end
      step();
    end
    n_checks++; if (sel_src1 !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL t2_sel1: actual=%0d required=%0d", sel_src1, (FWD ? 2 : 0)); end
    nop();
    exp_cnt += n;
    n_checks++; if (stall_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL t2_cnt: actual=%0d required=%0d", stall_cnt, exp_cnt); end
  endtask

  // LDR r3,[r8] ; ADD r4,r9,r3 (dependency on src2)
  task automatic test_load_use();
    int n;
    n = FWD ? 1 : 2;
    drain();
    issue(1'b1, 1'b1, 1'b1, 4'd3, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd4, 4'd9, 4'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== (i < n)) begin n_fail++; $display("FAIL t3_stall[%0d]: actual=%0b required=%0b", i, stall, (i < n)); end
      step();
    end
    n_checks++; if (sel_src2 !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL t3_sel2: actual=%0d required=%0d", sel_src2, (FWD ? 2 : 0)); end
    n_checks++; if (sel_src1 !== 2'd0) begin n_fail++; $display("FAIL t3_sel1: actual=%0d required=0", sel_src1); end
    nop();
    exp_cnt += n;
    n_checks++; if (stall_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL t3_cnt: actual=%0d required=%0d", stall_cnt, exp_cnt); end
  endtask

  // ADD r1 ; LDR r1,[r8] ; consumer of r1: the younger LDR governs
  task automatic test_youngest();
    int n;
    n = FWD ? 1 : 2;
    drain();
    issue(1'b1, 1'b1, 1'b0, 4'd1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    issue(1'b1, 1'b1, 1'b1, 4'd1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t4_ldr_stall: actual=%0b required=0", stall); end
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== (i < n)) begin n_fail++; $display("FAIL t4_stall[%0d]: actual=%0b required=%0b", i, stall, (i < n)); end
      step();
    end
    n_checks++; if (sel_src1 !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL t4_sel1: actual=%0d required=%0d", sel_src1, (FWD ? 2 : 0)); end
    nop();
    exp_cnt += n;
    n_checks++; if (stall_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL t4_cnt: actual=%0d required=%0d", stall_cnt, exp_cnt); end
  endtask

  // Load-use hazard in the same cycle as a flush: flush wins
  task automatic test_flush();
    drain();
    issue(1'b1, 1'b1, 1'b1, 4'd3, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd4, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t5_flush_stall: actual=%0b required=0", stall); end
    step();
    n_checks++; if (sel_src1 !== 2'd0) begin n_fail++; $display("FAIL t5_bubble_sel1: actual=%0d required=0", sel_src1); end
    // the squashed r4 writer must not be in flight
    issue(1'b1, 1'b1, 1'b0, 4'd5, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t5_r4_stall: actual=%0b required=0", stall); end
    step();
    n_checks++; if (sel_src1 !== 2'd0) begin n_fail++; $display("FAIL t5_r4_sel1: actual=%0d required=0", sel_src1); end
    nop();
    n_checks++; if (stall_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL t5_cnt: actual=%0d required=%0d", stall_cnt, exp_cnt); end
  endtask

  // Drive 20 stall cycles into a 4-bit counter, then reset in the middle of a stall
  task automatic test_saturate_reset();
    int  total;
    int  cycles;
    logic st;
    total  = 0;
    cycles = 0;
    drain();
    while (total < 20 && cycles < 400) begin
      issue(1'b1, 1'b1, 1'b1, 4'd1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
      step(); cycles++;
      issue(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
      do begin
        @(negedge clk);
        st = stall;
        if (st) total++;
        step(); cycles++;
      end while (st && cycles < 400);
    end
    nop();
    n_checks++; if (total < 20) begin n_fail++; $display("FAIL t6_stall_cycles: actual=%0d required>=20 within budget", total); end
    n_checks++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL t6_saturate: actual=%0d required=15", stall_cnt); end
    issue(1'b1, 1'b1, 1'b1, 4'd1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL t6_pre_rst_stall: actual=%0b required=1", stall); end
    rst = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t6_rst_stall: actual=%0b required=0", stall); end
    n_checks++; if (sel_src1 !== 2'd0) begin n_fail++; $display("FAIL t6_rst_sel1: actual=%0d required=0", sel_src1); end
    n_checks++; if (sel_src2 !== 2'd0) begin n_fail++; $display("FAIL t6_rst_sel2: actual=%0d required=0", sel_src2); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL t6_rst_cnt: actual=%0d required=0", stall_cnt); end
    step();
    rst = 1'b1;
    nop();
    exp_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_fwd_exe();
    test_fwd_wb();
    test_load_use();
    test_youngest();
    test_flush();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
